// File: rtl/axi_lite_slave.sv
// rtl/axi_lite_slave.sv - AXI4-Lite register bank responder with independent write and read FSMs
module axi_lite_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t                 wstate;
    rstate_t                 rstate;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_W-1:0]       w_strb_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;

    logic                    commit;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_data;
    logic [STRB_W-1:0]       c_strb;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;

    // Word address beyond the bank means SLVERR; low two address bits are ignored.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> 2) < ADDR_WIDTH'(NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] reg_index(input logic [ADDR_WIDTH-1:0] a);
        return a[2 +: IDX_W];
    endfunction

    // Pick the write payload at the edge completing the second handshake (live or latched halves).
    always_comb begin
        commit = 1'b0;
        c_addr = aw_addr_q;
        c_data = w_data_q;
        c_strb = w_strb_q;
        case (wstate)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    c_addr = awaddr;
                    c_data = wdata;
                    c_strb = wstrb;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    commit = 1'b1;
                    c_data = wdata;
                    c_strb = wstrb;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    c_addr = awaddr;
                end
            end
            default: ;
        endcase
    end

    // Write channel FSM; readys come up on the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate    <= W_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (commit) begin
            wstate  <= W_RESP;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= in_range(c_addr) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= awaddr;
                        wstate    <= W_HAVE_A;
                        awready   <= 1'b0;
                        wready    <= 1'b1;
                    end else if (w_hs) begin
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                        wstate   <= W_HAVE_D;
                        awready  <= 1'b1;
                        wready   <= 1'b0;
                    end else begin
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                W_HAVE_A: ;
                W_HAVE_D: ;
                W_RESP: begin
                    if (bready) begin
                        wstate  <= W_IDLE;
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Register bank: byte-masked update on an in-range commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (commit && in_range(c_addr)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (c_strb[i]) begin
                    regs[reg_index(c_addr)][8*i +: 8] <= c_data[8*i +: 8];
                end
            end
        end
    end

    // Read channel FSM; data is captured from the bank at the AR edge (pre-write value).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate  <= R_DATA;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        if (in_range(araddr)) begin
                            rdata <= regs[reg_index(araddr)];
                            rresp <= RESP_OKAY;
                        end else begin
                            rdata <= '0;
                            rresp <= RESP_SLVERR;
                        end
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rstate  <= R_IDLE;
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_slave.sv
// tb/tb_axi_lite_slave.sv - randomized and directed bench for axi_lite_slave against a transaction-level model
module tb_axi_lite_slave;

    localparam int NR = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    always #5 clk = ~clk;

    axi_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake not seen within 50 cycles at %0t", name, $time);
    endtask

    // Transaction-level model: register array plus "what is outstanding" flags.
    logic [31:0] m_regs [NR];
    bit          m_rdy_on, m_have_aw, m_have_w, m_bpend, m_rpend;
    logic [31:0] m_aw_addr, m_w_data, m_rdata;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_bresp, m_rresp;
    bit          aw_fire, w_fire, ar_fire, b_fire, r_fire;
    bit          e_awr, e_wr, e_arr;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp, last_bresp;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) mask = mask | (32'hFF << (8 * i));
        end
        return (old & ~mask) | (d & mask);
    endfunction

    // Compare DUT against model at every negedge, then advance the model across the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_awready", 32'(awready), 32'd0);
                chk("rst_wready", 32'(wready), 32'd0);
                chk("rst_arready", 32'(arready), 32'd0);
                chk("rst_bvalid", 32'(bvalid), 32'd0);
                chk("rst_rvalid", 32'(rvalid), 32'd0);
                chk("rst_bresp", 32'(bresp), 32'd0);
                chk("rst_rresp", 32'(rresp), 32'd0);
                chk("rst_rdata", rdata, 32'd0);
                for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
                m_rdy_on = 0; m_have_aw = 0; m_have_w = 0; m_bpend = 0; m_rpend = 0;
                aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
            end else begin
                e_awr = m_rdy_on && !m_have_aw && !m_bpend;
                e_wr  = m_rdy_on && !m_have_w && !m_bpend;
                e_arr = m_rdy_on && !m_rpend;
                chk("awready", 32'(awready), 32'(e_awr));
                chk("wready", 32'(wready), 32'(e_wr));
                chk("arready", 32'(arready), 32'(e_arr));
                chk("bvalid", 32'(bvalid), 32'(m_bpend));
                chk("rvalid", 32'(rvalid), 32'(m_rpend));
                if (m_bpend) chk("bresp", 32'(bresp), 32'(m_bresp));
                if (m_rpend) begin
                    chk("rdata", rdata, m_rdata);
                    chk("rresp", 32'(rresp), 32'(m_rresp));
                end
                aw_fire = awvalid && e_awr;
                w_fire  = wvalid && e_wr;
                ar_fire = arvalid && e_arr;
                b_fire  = m_bpend && bready;
                r_fire  = m_rpend && rready;
                if (b_fire) last_bresp = bresp;
                if (r_fire) begin
                    last_rdata = rdata;
                    last_rresp = rresp;
                end
                if (ar_fire) begin
                    m_rpend = 1;
                    if ((araddr >> 2) < NR) begin
                        m_rdata = m_regs[int'(araddr >> 2)];
                        m_rresp = 2'b00;
                    end else begin
                        m_rdata = 32'h0;
                        m_rresp = 2'b10;
                    end
                end else if (r_fire) begin
                    m_rpend = 0;
                end
                if (b_fire) m_bpend = 0;
                if (aw_fire) begin m_have_aw = 1; m_aw_addr = awaddr; end
                if (w_fire) begin m_have_w = 1; m_w_data = wdata; m_w_strb = wstrb; end
                if (m_have_aw && m_have_w) begin
                    m_have_aw = 0;
                    m_have_w  = 0;
                    m_bpend   = 1;
                    if ((m_aw_addr >> 2) < NR) begin
                        m_regs[int'(m_aw_addr >> 2)] = merge(m_regs[int'(m_aw_addr >> 2)], m_w_data, m_w_strb);
                        m_bresp = 2'b00;
                    end else begin
                        m_bresp = 2'b10;
                    end
                end
                m_rdy_on = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: same cycle.
    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        bit aw_done = 0;
        bit w_done  = 0;
        int c = 0;
        while (!(aw_done && w_done) && c < 50) begin
            if (!aw_done && !awvalid && c >= lead) begin awvalid = 1; awaddr = a; end
            if (!w_done && !wvalid && c >= -lead) begin wvalid = 1; wdata = d; wstrb = s; end
            tick();
            c++;
            if (aw_fire) begin aw_done = 1; awvalid = 0; end
            if (w_fire) begin w_done = 1; wvalid = 0; end
            if (lead > 0 && w_done && !aw_done) begin
                chk("wfirst_wready", 32'(wready), 32'd0);
                chk("wfirst_awready", 32'(awready), 32'd1);
            end
            if (lead < 0 && aw_done && !w_done) begin
                chk("awfirst_awready", 32'(awready), 32'd0);
                chk("awfirst_wready", 32'(wready), 32'd1);
            end
        end
        if (!(aw_done && w_done)) timeout("send_aw_w");
        else chk("b_latency", 32'(bvalid), 32'd1);
    endtask

    task automatic wait_b();
        int n = 0;
        bready = 1;
        do begin tick(); n++; end while (!b_fire && n < 50);
        if (!b_fire) timeout("wait_b");
        bready = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        send_aw_w(a, d, s, lead);
        wait_b();
    endtask

    task automatic rd(input logic [31:0] a);
        int n = 0;
        arvalid = 1; araddr = a; rready = 1;
        do begin tick(); n++; end while (!ar_fire && n < 50);
        arvalid = 0;
        if (!ar_fire) timeout("rd_ar");
        else chk("r_latency", 32'(rvalid), 32'd1);
        n = 0;
        do begin tick(); n++; end while (!r_fire && n < 50);
        if (!r_fire) timeout("rd_r");
        rready = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arvalid = 0; rready = 0;
        last_rdata = 0; last_rresp = 0; last_bresp = 0;
        repeat (3) tick();
        chk("reset_readys", 32'({awready, wready, arready}), 32'd0);
        rst = 1;
        chk("readys_held_at_release", 32'({awready, wready, arready}), 32'd0);
        tick();
        chk("readys_after_release", 32'({awready, wready, arready}), 32'h7);

        wr(32'h4, 32'hDEADBEEF, 4'hF, 0);
        chk("w4_bresp", 32'(last_bresp), 32'd0);
        rd(32'h4);
        chk("r4_rdata", last_rdata, 32'hDEADBEEF);
        chk("r4_rresp", 32'(last_rresp), 32'd0);

        wr(32'h8, 32'h12345678, 4'hF, 3);
        rd(32'h8);
        chk("wfirst_rdata", last_rdata, 32'h12345678);
        wr(32'h10, 32'h0BADF00D, 4'hF, -3);
        rd(32'h10);
        chk("awfirst_rdata", last_rdata, 32'h0BADF00D);

        wr(32'h8, 32'hAABBCCDD, 4'b0101, 0);
        rd(32'h8);
        chk("partial_strobe", last_rdata, 32'h12BB56DD);

        wr(32'h40, 32'hFFFFFFFF, 4'hF, 0);
        chk("oor_bresp", 32'(last_bresp), 32'd2);
        rd(32'h40);
        chk("oor_rresp", 32'(last_rresp), 32'd2);
        chk("oor_rdata", last_rdata, 32'd0);
        rd(32'h4);
        chk("oor_no_change", last_rdata, 32'hDEADBEEF);

        // Backpressure: both responses stall for 5 cycles.
        awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF;
        arvalid = 1; araddr = 32'h4;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", 32'(bvalid), 32'd1);
            chk("bp_rvalid", 32'(rvalid), 32'd1);
            chk("bp_readys", 32'({awready, wready, arready}), 32'd0);
            chk("bp_rdata", rdata, 32'hDEADBEEF);
            chk("bp_resps", 32'({bresp, rresp}), 32'd0);
            tick();
        end
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        chk("bp_released", 32'({bvalid, rvalid}), 32'd0);

        // Same-edge read and write of 0xC returns the old value.
        wr(32'hC, 32'h1, 4'hF, 0);
        bready = 1; rready = 1;
        awvalid = 1; awaddr = 32'hC; wvalid = 1; wdata = 32'h2; wstrb = 4'hF;
        arvalid = 1; araddr = 32'hC;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        tick();
        bready = 0; rready = 0;
        chk("same_edge_old", last_rdata, 32'h1);
        rd(32'hC);
        chk("same_edge_new", last_rdata, 32'h2);

        // Reset while a write response is pending.
        send_aw_w(32'h18, 32'h77, 4'hF, 0);
        tick();
        #2;
        rst = 0;
        #1;
        chk("async_bvalid_drop", 32'(bvalid), 32'd0);
        chk("async_readys_drop", 32'({awready, wready, arready}), 32'd0);
        tick();
        tick();
        rst = 1;
        tick();
        for (int i = 0; i < NR; i++) begin
            rd(32'(i * 4));
            chk("post_reset_zero", last_rdata, 32'd0);
        end

        // Random traffic on both channels.
        for (int c = 0; c < 1500; c++) begin
            if (!awvalid && $urandom_range(0, 2) == 0) begin awvalid = 1; awaddr = rand_addr(); end
            if (!wvalid && $urandom_range(0, 2) == 0) begin
                wvalid = 1; wdata = $urandom; wstrb = 4'($urandom_range(0, 15));
            end
            if (!arvalid && $urandom_range(0, 2) == 0) begin arvalid = 1; araddr = rand_addr(); end
            bready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
            tick();
            if (aw_fire) awvalid = 0;
            if (w_fire) wvalid = 0;
            if (ar_fire) arvalid = 0;
        end
        bready = 1; rready = 1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (aw_fire) awvalid = 0;
            if (w_fire) wvalid = 0;
            if (ar_fire) arvalid = 0;
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        tick();
        tick();
        for (int i = 0; i < NR; i++) rd(32'(i * 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave.md
Name: axi_lite_slave

Overview:
AXI4-Lite responder with a bank of NUM_REGS software-visible 32-bit registers. It answers the write (AW/W/B) and read (AR/R) channels from an AXI4-Lite initiator on the same axi_lite_if. Write and read paths are independent state machines, so one write and one read can be in flight at once. Out-of-range accesses complete with SLVERR and change nothing.

Parameters:
ADDR_WIDTH, 32, address width (axi_lite_pkg value)
DATA_WIDTH, 32, data width (axi_lite_pkg value); wstrb width = DATA_WIDTH/8
NUM_REGS, 16, number of registers; byte address range 0 .. NUM_REGS*4-1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte enables
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response: OKAY/SLVERR
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Reset (rst=0): all registers 0. awready, wready, arready, bvalid, rvalid = 0. bresp, rresp, rdata = 0. Any in-flight transaction is dropped. A ready flop sets on the first clk edge after rst=1, so readys can rise one cycle after release at the earliest.
- Decode: index = addr[2 +: clog2(NUM_REGS)] and addr[1:0] are ignored. The access is in range iff (addr >> 2) < NUM_REGS; otherwise SLVERR.
- Write FSM states and readys:
  - W_IDLE: awready=1, wready=1.
  - W_HAVE_A (AW captured): awready=0, wready=1.
  - W_HAVE_D (W captured): awready=1, wready=0.
  - W_RESP: both readys 0, bvalid=1.
- Write handshakes: each handshake latches its payload. AW and W may arrive in either order or in the same cycle.
- Write commit: on the edge that completes the second of the two handshakes, or both together:
  - In range: byte i of the register is written iff wstrb[i]; bresp=OKAY.
  - Out of range: no write; bresp=SLVERR.
  - Then enter W_RESP. bvalid and the new register value are visible the next cycle.
- W_RESP: bvalid, bresp are held stable until bready=1, then go to W_IDLE with bvalid=0 the next cycle. wstrb=0 gives OKAY with no change.
- Read FSM states:
  - R_IDLE: arready=1. On an AR handshake, rdata is registered from the register at that edge (pre-write value if a write commits on the same edge). rresp is OKAY, or SLVERR with rdata=0 if out of range. Go to R_DATA.
  - R_DATA: arready=0, rvalid=1; rdata, rresp held stable until rready=1, then go to R_IDLE.
- Latency: AR handshake at edge k gives rvalid at k+1. Completion of the second write handshake at edge k gives bvalid at k+1. Back-to-back throughput is one transaction per 2 cycles per channel when ready/valid are held high.
- Valid outputs never drop without the matching ready. The slave never waits for a valid before raising its ready.
- Simultaneous read and write to the same register: the read returns the old value. Reads and writes to different registers are fully independent.
- Reset asserted mid-transaction: outputs clear immediately (asynchronous). After release, the block idles with no stale response.

Test Plan:
- Reset, then write 0x0000_0004 <= 0xDEADBEEF with AW and W in the same cycle, wstrb=4'hF -> bvalid at +1 cycle, bresp=00; read 0x4 -> rvalid at +1, rdata=0xDEADBEEF, rresp=00.
- W sent 3 cycles before AW (addr 0x8, data 0x12345678) -> wready=0 while waiting, awready=1; one B response; read 0x8 returns 0x12345678. Repeat with AW first.
- Partial strobe: reg 0x8=0x12345678, write 0xAABBCCDD with wstrb=4'b0101 -> read 0x8 = 0x12BB56DD.
- Out-of-range: NUM_REGS=16, write 0x40 -> bresp=10, no register changed; read 0x40 -> rresp=10, rdata=0.
- Backpressure: hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid, bresp/rresp, rdata stable; awready=wready=arready=0 throughout.
- Same-edge read/write on 0xC (old 0x1, new 0x2) -> read returns 0x1, a later read returns 0x2. Assert rst mid-W_RESP -> bvalid drops immediately and all registers read 0 after release.
